quad_splitter: RTL and testbench

Sequential, parametrised successor to the combinational quad breaker in the GPU front end. It accepts one primitive per handshake, either a quad (v0..v3) or a pass-through triangle. It classifies a quad as regular, chevron or bowtie, computes the bowtie crossing point with a serial signed divider, and streams one or two triangles to the rasteriser set-up stage over a valid/ready interface. Coordinates are signed, which generalises the unsigned-only arithmetic of the earlier block.

---
 rtl/quad_splitter.sv | 236 +++++++++++++++++++++++
 tb/tb_quad_splitter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_splitter.sv
// rtl/quad_splitter.sv - splits a quad (or passes a triangle) into a registered triangle stream
module quad_splitter #(
    parameter int COORD_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_is_tri,
    input  logic signed [COORD_W-1:0] in_x0,
    input  logic signed [COORD_W-1:0] in_x1,
    input  logic signed [COORD_W-1:0] in_x2,
    input  logic signed [COORD_W-1:0] in_x3,
    input  logic signed [COORD_W-1:0] in_y0,
    input  logic signed [COORD_W-1:0] in_y1,
    input  logic signed [COORD_W-1:0] in_y2,
    input  logic signed [COORD_W-1:0] in_y3,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [COORD_W-1:0] out_x0,
    output logic signed [COORD_W-1:0] out_x1,
    output logic signed [COORD_W-1:0] out_x2,
    output logic signed [COORD_W-1:0] out_y0,
    output logic signed [COORD_W-1:0] out_y1,
    output logic signed [COORD_W-1:0] out_y2,
    output logic                      out_last,
    output logic [1:0]                out_kind,
    output logic                      out_degen
);
    localparam int NUM_W = 3*COORD_W+3;
    localparam int CNT_W = $clog2(NUM_W);

    typedef enum logic [2:0] {IDLE, CLASS, DIV, EMIT0, EMIT1} state_t;
    state_t state, state_nxt;

    logic signed [COORD_W-1:0] vx [4];
    logic signed [COORD_W-1:0] vy [4];
    logic                      tri_q;
    logic signed [COORD_W-1:0] t0x [3];
    logic signed [COORD_W-1:0] t0y [3];
    logic signed [COORD_W-1:0] t1x [3];
    logic signed [COORD_W-1:0] t1y [3];
    logic [1:0]                kind_q;
    logic                      degen_q;
    logic [NUM_W-1:0]          quo_x, quo_y, rem_x, rem_y, dv;
    logic                      neg_x, neg_y;
    logic [CNT_W-1:0]          cnt;

    logic [1:0] s0, s1, s2, s3, q_idx, r_idx, kind_c;
    logic       bow, chev12, chev03, alt, go_div, degen_c, last_step;
    logic [1:0] ia [3];
    logic [1:0] ja [3];
    logic signed [NUM_W-1:0] px_e, py_e, qx_e, qy_e, rx_e, ry_e, sx_e, sy_e;
    logic signed [NUM_W-1:0] d1x, d1y, d2x, d2y, a_c, b_c, c_c, nx_c, ny_c;
    logic [2*NUM_W-1:0]      stx, sty;
    logic signed [COORD_W-1:0] pxs, pys;

    function automatic logic signed [NUM_W-1:0] ext(input logic signed [COORD_W-1:0] v);
        return {{(NUM_W-COORD_W){v[COORD_W-1]}}, v};
    endfunction

    // Sign of the cross product: 01 = positive, 00 = zero, 10 = negative
    function automatic logic [1:0] side(input logic signed [COORD_W-1:0] ax, ay, bx, by, px, py);
        logic signed [NUM_W-1:0] cr;
        cr = (ext(bx) - ext(ax)) * (ext(py) - ext(ay)) - (ext(by) - ext(ay)) * (ext(px) - ext(ax));
        if (cr == '0) return 2'b00;
        return cr[NUM_W-1] ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [NUM_W-1:0] mag(input logic signed [NUM_W-1:0] v);
        return v[NUM_W-1] ? -v : v;
    endfunction

    // One restoring step; returns {remainder, dividend/quotient shift register}
    function automatic logic [2*NUM_W-1:0] div_step(input logic [NUM_W-1:0] rem, quo, d);
        logic [NUM_W:0] trial;
        trial = {rem, quo[NUM_W-1]};
        if (trial >= {1'b0, d}) return {NUM_W'(trial - {1'b0, d}), quo[NUM_W-2:0], 1'b1};
        return {trial[NUM_W-1:0], quo[NUM_W-2:0], 1'b0};
    endfunction

    function automatic logic signed [COORD_W-1:0] sat(input logic [NUM_W-1:0] m, input logic neg);
        logic [NUM_W-1:0] lim;
        lim = NUM_W'(1) << (COORD_W-1);
        if (m >= lim) return neg ? {1'b1, {(COORD_W-1){1'b0}}} : {1'b0, {(COORD_W-1){1'b1}}};
        return neg ? -m[COORD_W-1:0] : m[COORD_W-1:0];
    endfunction

    always_comb begin
        s0 = side(vx[1], vy[1], vx[2], vy[2], vx[0], vy[0]);
        s3 = side(vx[1], vy[1], vx[2], vy[2], vx[3], vy[3]);
        s1 = side(vx[0], vy[0], vx[3], vy[3], vx[1], vy[1]);
        s2 = side(vx[0], vy[0], vx[3], vy[3], vx[2], vy[2]);
        bow    = (s0 == s3) && (s1 == s2);
        chev12 = (s0 != s3) && (s1 == s2);
        chev03 = (s0 == s3) && (s1 != s2);
        alt    = side(vx[0], vy[0], vx[2], vy[2], vx[1], vy[1]) !=
                 side(vx[0], vy[0], vx[2], vy[2], vx[3], vy[3]);
        // Crossing lines are (v0,vq) and (vr,v3); T0=(P,v0,vr), T1=(P,vq,v3)
        q_idx = alt ? 2'd2 : 2'd1;
        r_idx = alt ? 2'd1 : 2'd2;
        px_e = ext(vx[0]);     py_e = ext(vy[0]);
        qx_e = ext(vx[q_idx]); qy_e = ext(vy[q_idx]);
        rx_e = ext(vx[r_idx]); ry_e = ext(vy[r_idx]);
        sx_e = ext(vx[3]);     sy_e = ext(vy[3]);
        d1x  = px_e - qx_e;    d1y = py_e - qy_e;
        d2x  = rx_e - sx_e;    d2y = ry_e - sy_e;
        a_c  = px_e * qy_e - qx_e * py_e;
        b_c  = rx_e * sy_e - sx_e * ry_e;
        c_c  = d1x * d2y - d1y * d2x;
        nx_c = a_c * d2x - b_c * d1x;
        ny_c = a_c * d2y - b_c * d1y;

        kind_c = 2'd1;
        ia[0] = 2'd0; ia[1] = 2'd3; ia[2] = 2'd1;
        ja[0] = 2'd0; ja[1] = 2'd3; ja[2] = 2'd2;
        if (tri_q) begin
            kind_c = 2'd0;
            ia[1] = 2'd1; ia[2] = 2'd2;
            ja[1] = 2'd1; ja[2] = 2'd2;
        end else if (bow) begin
            kind_c = 2'd3;
            ia[1] = 2'd0;  ia[2] = r_idx;
            ja[1] = q_idx; ja[2] = 2'd3;
        end else if (chev12) begin
            kind_c = 2'd2;
            ia[0] = 2'd1; ia[1] = 2'd2; ia[2] = 2'd0;
            ja[0] = 2'd1; ja[1] = 2'd2; ja[2] = 2'd3;
        end else if (chev03) begin
            kind_c = 2'd2;
        end
        degen_c = !tri_q && bow && (c_c == '0);
        go_div  = !tri_q && bow && (c_c != '0);

        stx = div_step(rem_x, quo_x, dv);
        sty = div_step(rem_y, quo_y, dv);
        pxs = sat(stx[NUM_W-1:0], neg_x);
        pys = sat(sty[NUM_W-1:0], neg_y);
        last_step = (cnt == CNT_W'(NUM_W-1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_nxt = CLASS;
            CLASS:   state_nxt = go_div ? DIV : EMIT0;
            DIV:     if (last_step) state_nxt = EMIT0;
            EMIT0:   if (out_ready) state_nxt = tri_q ? IDLE : EMIT1;
            EMIT1:   if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_kind  <= '0;
            out_degen <= 1'b0;
            out_x0 <= '0; out_x1 <= '0; out_x2 <= '0;
            out_y0 <= '0; out_y1 <= '0; out_y2 <= '0;
            tri_q <= 1'b0; kind_q <= '0; degen_q <= 1'b0;
            quo_x <= '0; quo_y <= '0; rem_x <= '0; rem_y <= '0; dv <= '0;
            neg_x <= 1'b0; neg_y <= 1'b0; cnt <= '0;
            for (int k = 0; k < 4; k++) begin
                vx[k] <= '0; vy[k] <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                t0x[k] <= '0; t0y[k] <= '0; t1x[k] <= '0; t1y[k] <= '0;
            end
        end else begin
            in_ready <= (state_nxt == IDLE);
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    vx[0] <= in_x0; vx[1] <= in_x1; vx[2] <= in_x2; vx[3] <= in_x3;
                    vy[0] <= in_y0; vy[1] <= in_y1; vy[2] <= in_y2; vy[3] <= in_y3;
                    tri_q <= in_is_tri;
                end
                CLASS: begin
                    for (int k = 0; k < 3; k++) begin
                        t0x[k] <= vx[ia[k]]; t0y[k] <= vy[ia[k]];
                        t1x[k] <= vx[ja[k]]; t1y[k] <= vy[ja[k]];
                    end
                    kind_q  <= kind_c;
                    degen_q <= degen_c;
                    quo_x <= mag(nx_c); quo_y <= mag(ny_c);
                    rem_x <= '0;        rem_y <= '0;
                    dv    <= mag(c_c);
                    neg_x <= nx_c[NUM_W-1] ^ c_c[NUM_W-1];
                    neg_y <= ny_c[NUM_W-1] ^ c_c[NUM_W-1];
                    cnt   <= '0;
                    if (!go_div) begin
                        out_valid <= 1'b1;
                        out_last  <= tri_q;
                        out_kind  <= kind_c;
                        out_degen <= degen_c;
                        out_x0 <= vx[ia[0]]; out_x1 <= vx[ia[1]]; out_x2 <= vx[ia[2]];
                        out_y0 <= vy[ia[0]]; out_y1 <= vy[ia[1]]; out_y2 <= vy[ia[2]];
                    end
                end
                DIV: begin
                    rem_x <= stx[2*NUM_W-1:NUM_W]; quo_x <= stx[NUM_W-1:0];
                    rem_y <= sty[2*NUM_W-1:NUM_W]; quo_y <= sty[NUM_W-1:0];
                    cnt   <= cnt + CNT_W'(1);
                    if (last_step) begin
                        t0x[0] <= pxs; t0y[0] <= pys;
                        t1x[0] <= pxs; t1y[0] <= pys;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        out_kind  <= kind_q;
                        out_degen <= degen_q;
                        out_x0 <= pxs;    out_x1 <= t0x[1]; out_x2 <= t0x[2];
                        out_y0 <= pys;    out_y1 <= t0y[1]; out_y2 <= t0y[2];
                    end
                end
                EMIT0: if (out_ready) begin
                    if (tri_q) begin
                        out_valid <= 1'b0;
                    end else begin
                        out_last <= 1'b1;
                        out_x0 <= t1x[0]; out_x1 <= t1x[1]; out_x2 <= t1x[2];
                        out_y0 <= t1y[0]; out_y1 <= t1y[1]; out_y2 <= t1y[2];
                    end
                end
                EMIT1: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_quad_splitter.sv
// tb/tb_quad_splitter.sv - directed and randomized checks of quad_splitter against a behavioural model
module tb_quad_splitter;
    localparam int W     = 16;
    localparam int NUM_W = 3*W+3;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, in_is_tri, out_valid, out_ready, out_last, out_degen;
    logic [1:0] out_kind;
    logic signed [W-1:0] in_x0, in_x1, in_x2, in_x3, in_y0, in_y1, in_y2, in_y3;
    logic signed [W-1:0] out_x0, out_x1, out_x2, out_y0, out_y1, out_y2;

    int checks = 0;
    int failures = 0;
    int iv_x [4];
    int iv_y [4];
    logic itri;
    int ex [2][3];
    int ey [2][3];
    int ekind, en, elat;
    logic edegen;

    quad_splitter #(.COORD_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_is_tri(in_is_tri),
        .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3),
        .in_y0(in_y0), .in_y1(in_y1), .in_y2(in_y2), .in_y3(in_y3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x0(out_x0), .out_x1(out_x1), .out_x2(out_x2),
        .out_y0(out_y0), .out_y1(out_y1), .out_y2(out_y2),
        .out_last(out_last), .out_kind(out_kind), .out_degen(out_degen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int side_m(int a, int b, int p);
        longint cr;
        cr = longint'(iv_x[b] - iv_x[a]) * longint'(iv_y[p] - iv_y[a])
           - longint'(iv_y[b] - iv_y[a]) * longint'(iv_x[p] - iv_x[a]);
        return (cr > 0) ? 1 : ((cr < 0) ? -1 : 0);
    endfunction

    function automatic int sat_m(longint v);
        if (v > longint'((1 <<< (W-1)) - 1)) return (1 <<< (W-1)) - 1;
        if (v < -longint'(1 <<< (W-1))) return -(1 <<< (W-1));
        return int'(v);
    endfunction

    // Vertex index -1 stands for the crossing point P
    task automatic set_tri(input int k, input int a, input int b, input int c, input int pxv, input int pyv);
        int idx [3];
        idx[0] = a; idx[1] = b; idx[2] = c;
        for (int j = 0; j < 3; j++) begin
            ex[k][j] = (idx[j] < 0) ? pxv : iv_x[idx[j]];
            ey[k][j] = (idx[j] < 0) ? pyv : iv_y[idx[j]];
        end
    endtask

    task automatic build_expect();
        int s0, s1, s2, s3, p, q, r, s, pxv, pyv;
        longint d1x, d1y, d2x, d2y, a, b, c;
        edegen = 1'b0;
        elat = 1;
        if (itri) begin
            en = 1; ekind = 0;
            set_tri(0, 0, 1, 2, 0, 0);
        end else begin
            en = 2;
            s0 = side_m(1, 2, 0); s3 = side_m(1, 2, 3);
            s1 = side_m(0, 3, 1); s2 = side_m(0, 3, 2);
            if (s0 == s3 && s1 == s2) begin
                ekind = 3;
                if (side_m(0, 2, 1) == side_m(0, 2, 3)) begin p = 0; q = 1; r = 2; s = 3; end
                else begin p = 0; q = 2; r = 1; s = 3; end
                d1x = iv_x[p] - iv_x[q]; d1y = iv_y[p] - iv_y[q];
                d2x = iv_x[r] - iv_x[s]; d2y = iv_y[r] - iv_y[s];
                a = longint'(iv_x[p]) * iv_y[q] - longint'(iv_x[q]) * iv_y[p];
                b = longint'(iv_x[r]) * iv_y[s] - longint'(iv_x[s]) * iv_y[r];
                c = d1x * d2y - d1y * d2x;
                if (c == 0) begin
                    pxv = iv_x[0]; pyv = iv_y[0]; edegen = 1'b1;
                end else begin
                    pxv = sat_m((a * d2x - b * d1x) / c);
                    pyv = sat_m((a * d2y - b * d1y) / c);
                    elat = 1 + NUM_W;
                end
                if (q == 1) begin set_tri(0, -1, 0, 2, pxv, pyv); set_tri(1, -1, 1, 3, pxv, pyv); end
                else        begin set_tri(0, -1, 0, 1, pxv, pyv); set_tri(1, -1, 2, 3, pxv, pyv); end
            end else if (s0 != s3 && s1 == s2) begin
                ekind = 2;
                set_tri(0, 1, 2, 0, 0, 0); set_tri(1, 1, 2, 3, 0, 0);
            end else begin
                ekind = (s0 == s3) ? 2 : 1;
                set_tri(0, 0, 3, 1, 0, 0); set_tri(1, 0, 3, 2, 0, 0);
            end
        end
    endtask

    task automatic set_quad(input int x0, y0, x1, y1, x2, y2, x3, y3, input logic t);
        iv_x[0] = x0; iv_y[0] = y0; iv_x[1] = x1; iv_y[1] = y1;
        iv_x[2] = x2; iv_y[2] = y2; iv_x[3] = x3; iv_y[3] = y3;
        itri = t;
    endtask

    task automatic accept();
        int n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        chk("accept_ready", in_ready, 1);
        in_x0 = W'(iv_x[0]); in_x1 = W'(iv_x[1]); in_x2 = W'(iv_x[2]); in_x3 = W'(iv_x[3]);
        in_y0 = W'(iv_y[0]); in_y1 = W'(iv_y[1]); in_y2 = W'(iv_y[2]); in_y3 = W'(iv_y[3]);
        in_is_tri = itri;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_x0 = W'($urandom); in_x1 = W'($urandom); in_x2 = W'($urandom); in_x3 = W'($urandom);
        in_y0 = W'($urandom); in_y1 = W'($urandom); in_y2 = W'($urandom); in_y3 = W'($urandom);
        in_is_tri = 1'($urandom);
        chk("busy_after_accept", in_ready, 0);
    endtask

    // mode 0: always ready, 1: stall 5 then toggle, 2: random
    task automatic collect(input int mode);
        int k = 0, lat = 0, stall = 0, n = 0;
        logic seen = 1'b0;
        while (k < en && n < 400) begin
            if (out_valid) begin
                if (!seen) begin chk("first_latency", lat, elat); seen = 1'b1; end
                chk("out_x0", out_x0, ex[k][0]); chk("out_y0", out_y0, ey[k][0]);
                chk("out_x1", out_x1, ex[k][1]); chk("out_y1", out_y1, ey[k][1]);
                chk("out_x2", out_x2, ex[k][2]); chk("out_y2", out_y2, ey[k][2]);
                chk("out_last", out_last, (k == en - 1) ? 1 : 0);
                chk("out_kind", out_kind, ekind);
                chk("out_degen", out_degen, edegen);
                chk("busy_while_emitting", in_ready, 0);
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (stall >= 5) && ((stall % 2) == 1);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                stall++;
                if (out_ready) k++;
            end else begin
                out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            tick();
            lat++;
            n++;
        end
        out_ready = 1'b0;
        chk("emitted_count", k, en);
        chk("valid_after_last", out_valid, 0);
        chk("ready_after_last", in_ready, 1);
    endtask

    task automatic run(input int mode);
        build_expect();
        accept();
        collect(mode);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_kind"}, out_kind, 0);
        chk({tag, "_out_degen"}, out_degen, 0);
        chk({tag, "_out_coords"}, (out_x0 | out_x1 | out_x2 | out_y0 | out_y1 | out_y2), 0);
    endtask

    initial begin
        int stale;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_is_tri = 1'b0;
        in_x0 = '0; in_x1 = '0; in_x2 = '0; in_x3 = '0;
        in_y0 = '0; in_y1 = '0; in_y2 = '0; in_y3 = '0;
        tick(); tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_edge", in_ready, 0);
        tick();
        chk("ready_first_edge", in_ready, 1);

        set_quad(0, 0, 10, 0, 0, 10, 10, 10, 1'b0);     run(0);
        set_quad(0, 0, 10, 0, 0, 10, 10, 10, 1'b0);     run(0);
        set_quad(0, 0, 10, 0, 0, 10, 2, 2, 1'b0);       run(0);
        set_quad(0, 0, 10, 10, 10, 0, 0, 10, 1'b0);     run(0);
        set_quad(0, 0, -10, -10, -10, 0, 0, -10, 1'b0); run(0);
        set_quad(0, 0, 1, 1, 2, 2, 3, 3, 1'b0);         run(0);
        set_quad(0, 0, 10, 0, 0, 10, 10, 10, 1'b0);     run(1);
        set_quad(5, -3, 7, 9, -4, 2, 0, 0, 1'b1);       run(1);

        set_quad(0, 0, 10, 10, 10, 0, 0, 10, 1'b0);
        build_expect();
        accept();
        repeat (11) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_div_reset");
        tick(); tick();
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        #1;
        chk("release_ready_pre", in_ready, 0);
        tick();
        chk("release_ready", in_ready, 1);
        out_ready = 1'b1;
        stale = 0;
        repeat (60) begin
            if (out_valid) stale++;
            tick();
        end
        out_ready = 1'b0;
        chk("no_stale_triangle", stale, 0);
        set_quad(-7, 3, 12, -8, 4, 6, 0, 0, 1'b1);
        run(0);

        for (int i = 0; i < 40; i++) begin
            logic wide;
            wide = ($urandom_range(0, 3) == 0);
            for (int v = 0; v < 4; v++) begin
                iv_x[v] = wide ? int'($signed(16'($urandom))) : int'($urandom_range(0, 40)) - 20;
                iv_y[v] = wide ? int'($signed(16'($urandom))) : int'($urandom_range(0, 40)) - 20;
            end
            itri = ($urandom_range(0, 3) == 0);
            run(int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
